// File: rtl/jpeg_pkg.sv
// Shared constants, FSM state type and fragment-length clamp for the JPEG byte packer.
package jpeg_pkg;

   localparam logic [7:0] JPEG_FF       = 8'hFF;
   localparam logic [7:0] JPEG_STUFF    = 8'h00;
   localparam logic       PAD_BIT       = 1'b1;
   localparam int         MAX_FRAG_BITS = 8;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      PAD   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } packer_state_t;

   // Lengths 9..15 are treated as a full byte-wide fragment.
   function automatic logic [3:0] clamp_bits(input logic [3:0] bits);
      return (bits > 4'(MAX_FRAG_BITS)) ? 4'(MAX_FRAG_BITS) : bits;
   endfunction

endpackage

// File: rtl/jpeg_byte_packer_if.sv
// Fragment-in / byte-out handshake bundle; master drives fragments and out_ready, slave is the packer.
interface jpeg_byte_packer_if #(
   parameter int CNT_WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [7:0]           in_data;
   logic [3:0]           in_bits;
   logic                 flush_req;
   logic                 flush_done;
   logic                 out_valid;
   logic                 out_ready;
   logic [7:0]           out_byte;
   logic                 busy;
   logic [CNT_WIDTH-1:0] byte_count;

   modport master (
      output in_valid, in_data, in_bits, flush_req, out_ready,
      input  in_ready, flush_done, out_valid, out_byte, busy, byte_count
   );

   modport slave (
      input  in_valid, in_data, in_bits, flush_req, out_ready,
      output in_ready, flush_done, out_valid, out_byte, busy, byte_count
   );
endinterface

// File: rtl/jpeg_byte_packer_fifo.sv
// Synchronous byte FIFO; push-to-head latency one cycle; caller must not push when full unless popping.
// Head reads as 0 while empty so the output byte has a defined reset value.
module jpeg_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_push,
   input  logic [7:0] i_push_dat,
   input  logic       i_pop,
   output logic       o_full,
   output logic       o_empty,
   output logic [7:0] o_head
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]  r_mem [DEPTH];
   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end

   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_head  = o_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/jpeg_byte_packer.sv
// Packs 0..8-bit fragments MSB-first into bytes, stuffs 0x00 after 0xFF, pads with 1s on flush.
// Completed byte reaches the FIFO one edge after acceptance; full FIFO stalls extraction, then in_ready.
module jpeg_byte_packer
   import jpeg_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic               i_clock,
   input  logic               i_reset,
   jpeg_byte_packer_if.slave  bus
);
   packer_state_t        r_state, w_state_nxt;
   logic [15:0]          r_acc, w_acc_nxt, w_acc_base, w_pad_mask;
   logic [3:0]           r_acc_cnt, w_cnt_nxt, w_cnt_base;
   logic                 r_stuff_pend, w_stuff_nxt;
   logic                 r_rdy_en;
   logic [CNT_WIDTH-1:0] r_byte_count;

   logic       w_fifo_full, w_fifo_empty;
   logic [7:0] w_head;
   logic [3:0] w_bits;
   logic [7:0] w_frag_l;
   logic       w_in_rdy, w_accept, w_pop, w_can_push;
   logic       w_push_stuff, w_push_data, w_push;
   logic [7:0] w_push_byte;
   logic       w_flush_done;

   assign w_bits     = clamp_bits(bus.in_bits);
   assign w_frag_l   = bus.in_data << (4'd8 - w_bits);
   assign w_in_rdy   = r_rdy_en && (r_state == RUN) && (r_acc_cnt <= 4'd7);
   assign w_accept   = bus.in_valid && w_in_rdy;
   assign w_pop      = !w_fifo_empty && bus.out_ready;
   assign w_can_push = !w_fifo_full || w_pop;

   // A pending stuff byte always goes out before any further data byte.
   assign w_push_stuff = r_stuff_pend && w_can_push;
   assign w_push_data  = !r_stuff_pend && (r_acc_cnt >= 4'd8) && w_can_push;
   assign w_push       = w_push_stuff || w_push_data;
   assign w_push_byte  = w_push_stuff ? JPEG_STUFF : r_acc[15:8];

   always_comb begin
      w_acc_base   = w_push_data ? {r_acc[7:0], 8'h00} : r_acc;
      w_cnt_base   = w_push_data ? (r_acc_cnt - 4'd8) : r_acc_cnt;
      w_pad_mask   = (16'hFF00 >> w_cnt_base) & 16'hFF00;
      w_acc_nxt    = w_acc_base;
      w_cnt_nxt    = w_cnt_base;
      w_state_nxt  = r_state;
      w_flush_done = 1'b0;
      w_stuff_nxt  = r_stuff_pend;

      if (w_push_stuff)
         w_stuff_nxt = 1'b0;
      else if (w_push_data && (r_acc[15:8] == JPEG_FF))
         w_stuff_nxt = 1'b1;

      if (w_accept) begin
         w_acc_nxt = w_acc_base | ({w_frag_l, 8'h00} >> w_cnt_base);
         w_cnt_nxt = w_cnt_base + w_bits;
      end

      case (r_state)
         RUN: begin
            if (bus.flush_req) w_state_nxt = PAD;
         end
         PAD: begin
            // Pad only once the count fits below one byte, so it never exceeds 15.
            if (w_cnt_base < 4'd8) begin
               if (w_cnt_base != 4'd0) begin
                  w_acc_nxt = PAD_BIT ? (w_acc_base | w_pad_mask) : (w_acc_base & ~w_pad_mask);
                  w_cnt_nxt = 4'd8;
               end
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if ((r_acc_cnt == 4'd0) && !r_stuff_pend && w_fifo_empty) w_state_nxt = DONE;
         end
         DONE: begin
            w_flush_done = 1'b1;
            w_state_nxt  = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= RUN;
         r_acc        <= '0;
         r_acc_cnt    <= '0;
         r_stuff_pend <= 1'b0;
         r_rdy_en     <= 1'b0;
         r_byte_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_acc_cnt    <= w_cnt_nxt;
         r_stuff_pend <= w_stuff_nxt;
         r_rdy_en     <= 1'b1;
         if (w_pop) r_byte_count <= r_byte_count + 1'b1;
      end
   end

   jpeg_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clock    (i_clock),
      .i_reset    (i_reset),
      .i_push     (w_push),
      .i_push_dat (w_push_byte),
      .i_pop      (w_pop),
      .o_full     (w_fifo_full),
      .o_empty    (w_fifo_empty),
      .o_head     (w_head)
   );

   assign bus.in_ready   = w_in_rdy;
   assign bus.out_valid  = !w_fifo_empty;
   assign bus.out_byte   = w_head;
   assign bus.flush_done = w_flush_done;
   assign bus.busy       = (r_acc_cnt != 4'd0) || r_stuff_pend || !w_fifo_empty || (r_state != RUN);
   assign bus.byte_count = r_byte_count;
endmodule

// File: tb/tb_jpeg_byte_packer.sv
// Scoreboarded bench: a bit-queue model of the packed stream predicts every output byte.
module tb_jpeg_byte_packer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jpeg_byte_packer_if #(.CNT_WIDTH(16)) bus ();

   jpeg_byte_packer #(.FIFO_DEPTH(4), .CNT_WIDTH(16)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   int         n_cmp    = 0;
   int         n_bad    = 0;
   int         n_popped = 0;
   int         rdy_mode = 1;
   logic [7:0] exp_q[$];
   bit         mbits[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Reference stream: bits appended in order, cut into bytes, 0xFF followed by 0x00.
   task automatic m_pack();
      logic [7:0] b;
      while (mbits.size() >= 8) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b = {b[6:0], mbits.pop_front()};
         exp_q.push_back(b);
         if (b == 8'hFF) exp_q.push_back(8'h00);
      end
   endtask

   task automatic m_frag(input logic [7:0] d, input logic [3:0] bits);
      int n;
      n = (bits > 4'd8) ? 8 : int'(bits);
      for (int i = n - 1; i >= 0; i--) mbits.push_back(d[i]);
      m_pack();
   endtask

   task automatic m_pad();
      while ((mbits.size() % 8) != 0) mbits.push_back(1'b1);
      m_pack();
   endtask

   always @(negedge clk) begin
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out_byte: got 0x%0h, required no byte", bus.out_byte);
         end else begin
            check("out_byte", bus.out_byte, exp_q.pop_front());
         end
         n_popped++;
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.out_ready = 1'b0;
         1:       bus.out_ready = 1'b1;
         default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [7:0] d, input logic [3:0] bits, input bit with_flush);
      bit ok;
      ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_bits  = bits;
      for (int t = 0; t < 400 && !ok; t++) begin
         @(negedge clk);
         if (bus.in_ready === 1'b1) begin
            ok = 1'b1;
            m_frag(d, bits);
            if (with_flush) begin
               bus.flush_req = 1'b1;
               m_pad();
            end
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.flush_req = 1'b0;
      if (!ok) fail_now("accept_timeout");
   endtask

   task automatic do_flush();
      bus.flush_req = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_req = 1'b0;
      m_pad();
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 2000 && !seen; t++) begin
         @(negedge clk);
         if (bus.flush_done === 1'b1) seen = 1'b1;
      end
      if (!seen) fail_now("flush_done_timeout");
      check("exp_empty_at_done", exp_q.size(), 0);
      @(negedge clk);
      check("flush_done_width", bus.flush_done, 1'b0);
      check("busy_after_flush", bus.busy, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic [3:0] b;
      int         r;

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_bits   = 4'd0;
      bus.flush_req = 1'b0;
      bus.out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid",  bus.out_valid, 1'b0);
      check("rst_out_byte",   bus.out_byte, 8'h00);
      check("rst_flush_done", bus.flush_done, 1'b0);
      check("rst_busy",       bus.busy, 1'b0);
      check("rst_byte_count", bus.byte_count, 16'd0);
      check("rst_in_ready",   bus.in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("in_ready_after_rst", bus.in_ready, 1'b1);

      // Two nibbles form 0xAA; the byte shows one edge after the second accept.
      send(8'h0A, 4'd4, 1'b0);
      send(8'h0A, 4'd4, 1'b0);
      @(negedge clk);
      check("aa_not_yet_valid", bus.out_valid, 1'b0);
      @(negedge clk);
      check("aa_valid", bus.out_valid, 1'b1);
      check("aa_byte",  bus.out_byte, 8'hAA);
      @(posedge clk);
      #1;
      idle(3);
      check("aa_byte_count", bus.byte_count, 16'd1);

      send(8'hFF, 4'd8, 1'b0);
      idle(6);
      check("ff_byte_count", bus.byte_count, 16'd3);

      send(8'h05, 4'd3, 1'b0);
      do_flush();
      wait_done();

      send(8'h01, 4'd1, 1'b0);
      do_flush();
      wait_done();

      // Backpressure: FIFO holds 01..04, 05 waits in the accumulator.
      rdy_mode = 0;
      idle(2);
      for (int i = 1; i <= 5; i++) send(8'(i), 4'd8, 1'b0);
      idle(4);
      check("full_in_ready", bus.in_ready, 1'b0);
      check("full_out_valid", bus.out_valid, 1'b1);
      check("full_head", bus.out_byte, 8'h01);
      fork
         begin
            for (int i = 6; i <= 8; i++) send(8'(i), 4'd8, 1'b0);
         end
         begin
            idle(6);
            rdy_mode = 1;
         end
      join
      idle(20);
      check("full_drained", exp_q.size(), 0);
      check("full_byte_count", bus.byte_count, 32'(n_popped[15:0]));

      // Reset with a partial byte in the accumulator and a byte in the FIFO.
      rdy_mode = 0;
      idle(2);
      send(8'h77, 4'd8, 1'b0);
      send(8'h15, 4'd5, 1'b0);
      idle(3);
      check("pre_rst_busy", bus.busy, 1'b1);
      rst = 1'b1;
      #2;
      check("mid_rst_out_valid",  bus.out_valid, 1'b0);
      check("mid_rst_out_byte",   bus.out_byte, 8'h00);
      check("mid_rst_busy",       bus.busy, 1'b0);
      check("mid_rst_byte_count", bus.byte_count, 16'd0);
      check("mid_rst_flush_done", bus.flush_done, 1'b0);
      exp_q.delete();
      mbits.delete();
      n_popped = 0;
      @(negedge clk);
      rst = 1'b0;
      rdy_mode = 1;
      @(posedge clk);
      #1;
      idle(2);
      check("post_rst_busy", bus.busy, 1'b0);

      send(8'h3C, 4'd0, 1'b0);
      idle(8);
      check("zero_bits_no_output", bus.out_valid, 1'b0);
      check("zero_bits_busy", bus.busy, 1'b0);

      send(8'h5A, 4'd12, 1'b0);
      idle(6);
      check("clamp_drained", exp_q.size(), 0);
      check("clamp_byte_count", bus.byte_count, 16'd1);

      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         d = 8'($urandom);
         b = 4'($urandom_range(0, 15));
         r = $urandom_range(0, 19);
         if (r == 0) begin
            send(d, b, 1'b1);
            wait_done();
         end else begin
            send(d, b, 1'b0);
            if (r == 1) begin
               do_flush();
               wait_done();
            end
         end
      end
      do_flush();
      wait_done();
      idle(5);
      check("final_byte_count", bus.byte_count, 32'(n_popped[15:0]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
